// File: rtl/rocketcpu_wb_initiator.sv
// rocketcpu_wb_initiator
//   Wishbone classic single-transfer initiator. Takes one read/write command
//   on a valid/ready port, runs one bus cycle (cyc/stb held until ack) and
//   returns read data and status on a valid/ready response port.
//
//   Optional feature macro: ROCKETCPU_WBM_TIMEOUT_EN
//     defined   - watchdog aborts a transfer after TIMEOUT_CYCLES BUS cycles
//                 without ack (response with o_rsp_err=1, o_rsp_dat=0)
//     undefined - BUS waits for ack indefinitely, o_rsp_err tied 0
//
// Ports
//   i_wb_clk, i_wb_rst_n          clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready       command handshake
//   i_cmd_we/adr/dat/sel          command fields (write enable, address, data, byte enables)
//   o_rsp_valid/i_rsp_ready       response handshake
//   o_rsp_dat, o_rsp_err          read data (0 for writes/aborts), abort flag
//   o_wb_adr/dat/sel/we/cyc/stb   Wishbone initiator outputs
//   i_wb_rdt, i_wb_ack            Wishbone read data and acknowledge
module rocketcpu_wb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [31:0] i_cmd_adr,
    input  logic [31:0] i_cmd_dat,
    input  logic [3:0]  i_cmd_sel,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_dat,
    output logic        o_rsp_err,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_dat;
    logic [31:0] r_wb_adr;
    logic [31:0] r_wb_dat;
    logic [3:0]  r_wb_sel;
    logic        r_wb_we;
    logic        r_wb_cyc;

`ifdef ROCKETCPU_WBM_TIMEOUT_EN
    // Abort fires on the edge where the count would reach TIMEOUT_CYCLES,
    // so cyc stays high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_cnt;
    logic        r_rsp_err;
`endif

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_wb_adr    <= '0;
            r_wb_dat    <= '0;
            r_wb_sel    <= '0;
            r_wb_we     <= 1'b0;
            r_wb_cyc    <= 1'b0;
`ifdef ROCKETCPU_WBM_TIMEOUT_EN
            r_cnt       <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Ready is registered: it rises one edge after entering IDLE,
                    // so a command is never taken on the response handshake edge.
                    r_cmd_ready <= 1'b1;
                    if (i_cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_wb_we     <= i_cmd_we;
                        r_wb_adr    <= i_cmd_adr;
                        r_wb_dat    <= i_cmd_dat;
                        r_wb_sel    <= i_cmd_sel;
                        r_wb_cyc    <= 1'b1;
`ifdef ROCKETCPU_WBM_TIMEOUT_EN
                        r_cnt       <= '0;
`endif
                        r_state     <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (i_wb_ack) begin
                        r_wb_cyc    <= 1'b0;
                        r_rsp_dat   <= r_wb_we ? '0 : i_wb_rdt;
                        r_rsp_valid <= 1'b1;
`ifdef ROCKETCPU_WBM_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_state     <= S_RESP;
                    end
`ifdef ROCKETCPU_WBM_TIMEOUT_EN
                    else if (r_cnt == LP_LAST) begin
                        r_wb_cyc    <= 1'b0;
                        r_rsp_dat   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
`endif
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_dat   = r_rsp_dat;
    assign o_wb_adr    = r_wb_adr;
    assign o_wb_dat    = r_wb_dat;
    assign o_wb_sel    = r_wb_sel;
    assign o_wb_we     = r_wb_we;
    assign o_wb_cyc    = r_wb_cyc;
    assign o_wb_stb    = r_wb_cyc;
`ifdef ROCKETCPU_WBM_TIMEOUT_EN
    assign o_rsp_err   = r_rsp_err;
`else
    assign o_rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rocketcpu_wb_initiator.sv
// tb_rocketcpu_wb_initiator
//   Directed bench for rocketcpu_wb_initiator. A small register-bank responder
//   acks two edges after cyc rises (0x1000_001C reads a fixed 0xCAFE_0001),
//   and can be switched to never ack or have an ack pulse forced in.
//   Watchdog scenarios run only when ROCKETCPU_WBM_TIMEOUT_EN is defined.
module tb_rocketcpu_wb_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic [31:0] wb_adr, wb_dat, wb_rdt;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, wb_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rocketcpu_wb_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .i_wb_clk    (clk),
        .i_wb_rst_n  (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_we    (cmd_we),
        .i_cmd_adr   (cmd_adr),
        .i_cmd_dat   (cmd_dat),
        .i_cmd_sel   (cmd_sel),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_dat   (rsp_dat),
        .o_rsp_err   (rsp_err),
        .o_wb_adr    (wb_adr),
        .o_wb_dat    (wb_dat),
        .o_wb_sel    (wb_sel),
        .o_wb_we     (wb_we),
        .o_wb_cyc    (wb_cyc),
        .o_wb_stb    (wb_stb),
        .i_wb_rdt    (wb_rdt),
        .i_wb_ack    (wb_ack)
    );

    // Responder: counts edges with cyc high, acks while the count is 2.
    logic [31:0] mem [0:15];
    logic [1:0]  r_rcnt = 2'd0;
    logic        noack = 1'b0;
    logic        force_ack = 1'b0;

    assign wb_ack = (wb_cyc && r_rcnt == 2'd2 && !noack) || force_ack;
    assign wb_rdt = (wb_adr[5:2] == 4'h7) ? 32'hCAFE_0001 : mem[wb_adr[5:2]];

    always @(posedge clk) begin
        if (!wb_cyc) r_rcnt <= 2'd0;
        else if (r_rcnt != 2'd3) r_rcnt <= r_rcnt + 2'd1;
        if (wb_cyc && wb_ack && wb_we) begin
            for (int b = 0; b < 4; b++)
                if (wb_sel[b]) mem[wb_adr[5:2]][8*b +: 8] <= wb_dat[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one command from a negedge; return edges from acceptance to
    // rsp_valid (-1 if never), cyc-high samples, cyc pulses, and we seen on bus.
    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output int lat, output int cyc_hi,
                           output int pulses, output logic we_seen);
        int   n;
        logic prev;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_we = ~we; cmd_adr = 32'hDEAD_BEEF; cmd_dat = 32'h0BAD_F00D; cmd_sel = 4'h5;
        we_seen = wb_we;
        lat = -1; cyc_hi = 0; pulses = 0; prev = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (wb_cyc) begin
                cyc_hi++;
                if (!prev) pulses++;
            end
            prev = wb_cyc;
            if (rsp_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic respond();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int   lat, hi, pul;
        logic wes;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("rst_cyc",       {31'd0, wb_cyc},    32'd0);
        chk("rst_stb",       {31'd0, wb_stb},    32'd0);
        chk("rst_we",        {31'd0, wb_we},     32'd0);
        chk("rst_adr",       wb_adr,             32'd0);
        chk("rst_dat",       wb_dat,             32'd0);
        chk("rst_sel",       {28'd0, wb_sel},    32'd0);
        chk("rst_rsp_dat",   rsp_dat,            32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // 1: write
        run_cmd(1'b1, 32'h1000_0004, 32'h1234_5678, 4'hF, lat, hi, pul, wes);
        chk("wr_latency", lat, 32'd3);
        chk("wr_cyc_len", hi, 32'd3);
        chk("wr_cyc_pulses", pul, 32'd1);
        chk("wr_we", {31'd0, wes}, 32'd1);
        chk("wr_rsp_dat", rsp_dat, 32'd0);
        chk("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("wr_bus_adr", wb_adr, 32'h1000_0004);
        chk("wr_bus_dat", wb_dat, 32'h1234_5678);
        respond();
        chk("wr_rsp_cleared", {31'd0, rsp_valid}, 32'd0);

        // 2: read back, read fixed parameter register
        run_cmd(1'b0, 32'h1000_0004, 32'h0, 4'hF, lat, hi, pul, wes);
        chk("rd_latency", lat, 32'd3);
        chk("rd_we", {31'd0, wes}, 32'd0);
        chk("rd_rsp_dat", rsp_dat, 32'h1234_5678);
        chk("rd_rsp_err", {31'd0, rsp_err}, 32'd0);
        respond();
        run_cmd(1'b0, 32'h1000_001C, 32'h0, 4'hF, lat, hi, pul, wes);
        chk("rd_iparam", rsp_dat, 32'hCAFE_0001);
        respond();

        // 3: response back-pressure, command inputs ignored meanwhile
        run_cmd(1'b0, 32'h1000_0004, 32'h0, 4'hF, lat, hi, pul, wes);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h1000_0004; cmd_dat = 32'hFFFF_FFFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rsp_dat", rsp_dat, 32'h1234_5678);
            chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("hold_cyc", {31'd0, wb_cyc}, 32'd0);
        end
        cmd_valid = 1'b0;
        respond();
        chk("hs_ready_same", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("hs_ready_next", {31'd0, cmd_ready}, 32'd1);
        run_cmd(1'b0, 32'h1000_0004, 32'h0, 4'hF, lat, hi, pul, wes);
        chk("ignored_cmd_no_write", rsp_dat, 32'h1234_5678);
        respond();

`ifdef ROCKETCPU_WBM_TIMEOUT_EN
        // 4: watchdog abort, then normal transfer
        noack = 1'b1;
        run_cmd(1'b0, 32'h1000_001C, 32'h0, 4'hF, lat, hi, pul, wes);
        chk("to_latency", lat, 32'd16);
        chk("to_cyc_len", hi, 32'd16);
        chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("to_rsp_dat", rsp_dat, 32'd0);
        respond();
        noack = 1'b0;
        run_cmd(1'b0, 32'h1000_0004, 32'h0, 4'hF, lat, hi, pul, wes);
        chk("after_to_latency", lat, 32'd3);
        chk("after_to_err", {31'd0, rsp_err}, 32'd0);
        chk("after_to_dat", rsp_dat, 32'h1234_5678);
        respond();
`endif

        // 5: reset mid-BUS
        while (!cmd_ready) @(negedge clk);
        cmd_we = 1'b1; cmd_adr = 32'h1000_0008; cmd_dat = 32'h1111_1111; cmd_sel = 4'hF;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_bus_cyc", {31'd0, wb_cyc}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_cyc", {31'd0, wb_cyc}, 32'd0);
        chk("rst_async_stb", {31'd0, wb_stb}, 32'd0);
        chk("rst_async_rsp", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rel_no_rsp", {31'd0, rsp_valid}, 32'd0);
        run_cmd(1'b1, 32'h1000_0008, 32'hA5A5_5A5A, 4'hF, lat, hi, pul, wes);
        chk("rel_wr_latency", lat, 32'd3);
        respond();
        run_cmd(1'b0, 32'h1000_0008, 32'h0, 4'hF, lat, hi, pul, wes);
        chk("rel_rd_dat", rsp_dat, 32'hA5A5_5A5A);
        respond();

        // 6: stray acks in IDLE and RESP
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        chk("idle_ack_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("idle_ack_cyc", {31'd0, wb_cyc}, 32'd0);
        chk("idle_ack_ready", {31'd0, cmd_ready}, 32'd1);
        run_cmd(1'b0, 32'h1000_001C, 32'h0, 4'hF, lat, hi, pul, wes);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        chk("resp_ack_valid", {31'd0, rsp_valid}, 32'd1);
        chk("resp_ack_dat", rsp_dat, 32'hCAFE_0001);
        respond();
        chk("resp_ack_cleared", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        chk("no_extra_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("no_extra_cyc", {31'd0, wb_cyc}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
